l0_cache_lookup_unit: RTL and testbench

- Next-generation L0 data-cache lookup for the load path: N-way set-associative tag/valid store held in flops, with registered hit detection generalised over XLEN, ways, sets and access sizes.
- Also owns fill/merge of per-byte valid bits, round-robin victim selection, and a sequenced flush FSM.
- Sits between the EX-stage address generator and the load unit; the data array lives elsewhere and is indexed by {set, o_hit_way}.

---
 rtl/l0_cache_lookup_unit.sv | 171 +++++++++++++++++
 tb/tb_l0_cache_lookup_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l0_cache_lookup_unit.sv
// L0 data-cache tag/valid store: registered load hit detection, byte-granular fill/merge,
// round-robin victim selection per set and a set-by-set flush sequencer.
module l0_cache_lookup_unit #(
  parameter int XLEN                = 32,
  parameter int NumWays             = 2,
  parameter int NumSets             = 64,
  parameter int MEM_BYTE_ADDR_WIDTH = 16,
  parameter logic [XLEN-1:0] MMIO_ADDR = XLEN'(32'h4000_0000),
  localparam int B    = XLEN / 8,
  localparam int OffW = $clog2(B),
  localparam int IdxW = $clog2(NumSets),
  localparam int TagW = MEM_BYTE_ADDR_WIDTH - IdxW - OffW,
  localparam int WayW = (NumWays > 1) ? $clog2(NumWays) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_lookup_valid,
  input  logic [XLEN-1:0] i_lookup_addr,
  input  logic [1:0]      i_lookup_size,
  output logic            o_hit_valid,
  output logic            o_hit,
  output logic [WayW-1:0] o_hit_way,
  input  logic            i_fill_valid,
  input  logic [XLEN-1:0] i_fill_addr,
  input  logic [B-1:0]    i_fill_byte_en,
  input  logic            i_flush_req,
  output logic            o_flush_busy,
  output logic            o_flush_done
);

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e          r_state;
  logic [IdxW-1:0] r_flush_cnt;
  logic [TagW-1:0] r_tag    [NumSets][NumWays];
  logic [B-1:0]    r_valid  [NumSets][NumWays];
  logic [WayW-1:0] r_victim [NumSets];

  // Cacheable means below the MMIO window and inside the implemented address space.
  function automatic logic addr_ok(input logic [XLEN-1:0] a);
    return (a < MMIO_ADDR) && (a[XLEN-1:MEM_BYTE_ADDR_WIDTH] == '0);
  endfunction

  logic [OffW-1:0] w_lk_off;
  logic [IdxW-1:0] w_lk_set;
  logic [TagW-1:0] w_lk_tag;
  logic [7:0]      w_lk_ones;
  logic [2:0]      w_lk_amask;
  logic [B-1:0]    w_lk_need;
  logic            w_lk_elig;
  logic            w_hit;
  logic [WayW-1:0] w_hit_way;

  assign w_lk_off = i_lookup_addr[OffW-1:0];
  assign w_lk_set = i_lookup_addr[OffW+IdxW-1:OffW];
  assign w_lk_tag = i_lookup_addr[MEM_BYTE_ADDR_WIDTH-1:OffW+IdxW];

  always_comb begin
    case (i_lookup_size)
      2'd0:    begin w_lk_ones = 8'h01; w_lk_amask = 3'b000; end
      2'd1:    begin w_lk_ones = 8'h03; w_lk_amask = 3'b001; end
      2'd2:    begin w_lk_ones = 8'h0F; w_lk_amask = 3'b011; end
      default: begin w_lk_ones = 8'hFF; w_lk_amask = 3'b111; end
    endcase
    w_lk_need = B'(w_lk_ones) << w_lk_off;
    w_lk_elig = i_lookup_valid && (r_state == S_IDLE) && addr_ok(i_lookup_addr)
             && ((i_lookup_size != 2'd3) || (XLEN == 64))
             && ((w_lk_off & OffW'(w_lk_amask)) == '0);
  end

  // Scan from the top so the lowest-index matching way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = NumWays - 1; w >= 0; w--) begin
      if (w_lk_elig && (r_valid[w_lk_set][w] != '0) && (r_tag[w_lk_set][w] == w_lk_tag)
          && ((r_valid[w_lk_set][w] & w_lk_need) == w_lk_need)) begin
        w_hit     = 1'b1;
        w_hit_way = WayW'(w);
      end
    end
  end

  logic [IdxW-1:0] w_fl_set;
  logic [TagW-1:0] w_fl_tag;
  logic            w_fl_en;
  logic            w_fl_match;
  logic [WayW-1:0] w_fl_match_way;
  logic            w_fl_free;
  logic [WayW-1:0] w_fl_free_way;
  logic [WayW-1:0] w_fl_alloc_way;
  logic [WayW-1:0] w_fl_vic_next;

  assign w_fl_set = i_fill_addr[OffW+IdxW-1:OffW];
  assign w_fl_tag = i_fill_addr[MEM_BYTE_ADDR_WIDTH-1:OffW+IdxW];
  assign w_fl_en  = i_fill_valid && (r_state == S_IDLE) && addr_ok(i_fill_addr);

  always_comb begin
    w_fl_match     = 1'b0;
    w_fl_match_way = '0;
    w_fl_free      = 1'b0;
    w_fl_free_way  = '0;
    for (int w = NumWays - 1; w >= 0; w--) begin
      if ((r_valid[w_fl_set][w] != '0) && (r_tag[w_fl_set][w] == w_fl_tag)) begin
        w_fl_match     = 1'b1;
        w_fl_match_way = WayW'(w);
      end
      if (r_valid[w_fl_set][w] == '0) begin
        w_fl_free     = 1'b1;
        w_fl_free_way = WayW'(w);
      end
    end
    w_fl_alloc_way = w_fl_free ? w_fl_free_way : r_victim[w_fl_set];
    w_fl_vic_next  = (r_victim[w_fl_set] == WayW'(NumWays - 1)) ? '0
                   : r_victim[w_fl_set] + WayW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < NumSets; s++) begin
        for (int w = 0; w < NumWays; w++) begin
          r_tag[s][w]   <= '0;
          r_valid[s][w] <= '0;
        end
        r_victim[s] <= '0;
      end
      r_state      <= S_IDLE;
      r_flush_cnt  <= '0;
      o_hit_valid  <= 1'b0;
      o_hit        <= 1'b0;
      o_hit_way    <= '0;
      o_flush_busy <= 1'b0;
      o_flush_done <= 1'b0;
    end else begin
      o_hit_valid  <= i_lookup_valid;
      o_hit        <= w_hit;
      o_hit_way    <= w_hit_way;
      o_flush_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fl_en) begin
            if (w_fl_match) begin
              r_valid[w_fl_set][w_fl_match_way] <= r_valid[w_fl_set][w_fl_match_way] | i_fill_byte_en;
            end else if (i_fill_byte_en != '0) begin
              r_tag[w_fl_set][w_fl_alloc_way]   <= w_fl_tag;
              r_valid[w_fl_set][w_fl_alloc_way] <= i_fill_byte_en;
              if (!w_fl_free) r_victim[w_fl_set] <= w_fl_vic_next;
            end
          end
          if (i_flush_req) begin
            r_state      <= S_FLUSH;
            r_flush_cnt  <= '0;
            o_flush_busy <= 1'b1;
          end
        end
        S_FLUSH: begin
          for (int w = 0; w < NumWays; w++) r_valid[r_flush_cnt][w] <= '0;
          r_victim[r_flush_cnt] <= '0;
          r_flush_cnt           <= r_flush_cnt + IdxW'(1);
          if (r_flush_cnt == IdxW'(NumSets - 1)) begin
            r_state      <= S_IDLE;
            o_flush_busy <= 1'b0;
            o_flush_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l0_cache_lookup_unit.sv
// Bench for l0_cache_lookup_unit: a 32-bit/2-way instance against a line-level model,
// plus a 64-bit/4-way instance with directed dword/byte checks.
module tb_l0_cache_lookup_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_lv, a_hv, a_hit, a_hw, a_fv, a_freq, a_busy, a_done;
  logic [31:0] a_la, a_fa;
  logic [1:0]  a_ls;
  logic [3:0]  a_fbe;

  logic        b_lv, b_hv, b_hit, b_fv, b_freq, b_busy, b_done;
  logic [63:0] b_la, b_fa;
  logic [1:0]  b_ls, b_hw;
  logic [7:0]  b_fbe;

  l0_cache_lookup_unit dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_lookup_valid(a_lv), .i_lookup_addr(a_la), .i_lookup_size(a_ls),
    .o_hit_valid(a_hv), .o_hit(a_hit), .o_hit_way(a_hw),
    .i_fill_valid(a_fv), .i_fill_addr(a_fa), .i_fill_byte_en(a_fbe),
    .i_flush_req(a_freq), .o_flush_busy(a_busy), .o_flush_done(a_done)
  );

  l0_cache_lookup_unit #(.XLEN(64), .NumWays(4)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_lookup_valid(b_lv), .i_lookup_addr(b_la), .i_lookup_size(b_ls),
    .o_hit_valid(b_hv), .o_hit(b_hit), .o_hit_way(b_hw),
    .i_fill_valid(b_fv), .i_fill_addr(b_fa), .i_fill_byte_en(b_fbe),
    .i_flush_req(b_freq), .o_flush_busy(b_busy), .o_flush_done(b_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of instance A: 64 sets x 2 ways of (tag, byte-valid) lines.
  int unsigned m_tag [64][2];
  logic [3:0]  m_val [64][2];
  int          m_vic [64];
  bit          m_flushing;
  int          m_flush_left;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_tag[s][w] = 0;
        m_val[s][w] = 4'h0;
      end
      m_vic[s] = 0;
    end
    m_flushing   = 1'b0;
    m_flush_left = 0;
  endtask

  function automatic bit mem_addr(input logic [31:0] a);
    return (a < 32'h4000_0000) && (a < 32'h0001_0000);
  endfunction

  task automatic mdl_lookup(input logic [31:0] a, input logic [1:0] sz, output bit hit, output int way);
    int unsigned set, tg, off, nbytes, need;
    hit = 1'b0;
    way = 0;
    if (m_flushing || !mem_addr(a) || sz == 2'd3) return;
    nbytes = 1 << sz;
    off    = a % 4;
    if (off % nbytes != 0) return;
    need = ((1 << nbytes) - 1) << off;
    set  = (a / 4) % 64;
    tg   = a / 256;
    for (int w = 0; w < 2; w++) begin
      if (m_val[set][w] != 0 && m_tag[set][w] == tg && (m_val[set][w] & need) == need) begin
        hit = 1'b1;
        way = w;
        return;
      end
    end
  endtask

  task automatic mdl_fill(input logic [31:0] a, input logic [3:0] be);
    int unsigned set, tg;
    int way;
    if (!mem_addr(a)) return;
    set = (a / 4) % 64;
    tg  = a / 256;
    for (int w = 0; w < 2; w++) begin
      if (m_val[set][w] != 0 && m_tag[set][w] == tg) begin
        m_val[set][w] = m_val[set][w] | be;
        return;
      end
    end
    if (be == 4'h0) return;
    way = -1;
    for (int w = 0; w < 2; w++) if (m_val[set][w] == 0 && way < 0) way = w;
    if (way < 0) begin
      way        = m_vic[set];
      m_vic[set] = (m_vic[set] + 1) % 2;
    end
    m_tag[set][way] = tg;
    m_val[set][way] = be;
  endtask

  // One clock of instance A: drive, predict from pre-edge model, advance model, check.
  task automatic cyc(input bit lv, input logic [31:0] la, input logic [1:0] ls,
                     input bit fv, input logic [31:0] fa, input logic [3:0] fbe, input bit freq);
    bit eh, edone;
    int ew;
    a_lv = lv; a_la = la; a_ls = ls;
    a_fv = fv; a_fa = fa; a_fbe = fbe; a_freq = freq;
    mdl_lookup(la, ls, eh, ew);
    if (!lv) begin eh = 1'b0; ew = 0; end
    @(posedge clk); #1;
    edone = 1'b0;
    if (m_flushing) begin
      m_flush_left--;
      if (m_flush_left == 0) begin
        mdl_reset();
        edone = 1'b1;
      end
    end else begin
      if (fv) mdl_fill(fa, fbe);
      if (freq) begin
        m_flushing   = 1'b1;
        m_flush_left = 64;
      end
    end
    chk("hit_valid", a_hv, lv);
    chk("hit", a_hit, eh);
    chk("hit_way", a_hw, ew);
    chk("flush_busy", a_busy, m_flushing);
    chk("flush_done", a_done, edone);
  endtask

  task automatic look(input logic [31:0] la, input logic [1:0] ls);
    cyc(1'b1, la, ls, 1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic fill(input logic [31:0] fa, input logic [3:0] fbe);
    cyc(1'b0, 32'h0, 2'd0, 1'b1, fa, fbe, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic exp_a(input string tag, input bit h, input bit w);
    chk(tag, {a_hit, a_hw}, {h, w});
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 32'h4000_0000 | ($urandom_range(0, 63) << 2);
    if (r == 1) return 32'h0001_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
    return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    rst = 1'b1;
    a_lv = 0; a_la = 0; a_ls = 0; a_fv = 0; a_fa = 0; a_fbe = 0; a_freq = 0;
    b_lv = 0; b_la = 0; b_ls = 0; b_fv = 0; b_fa = 0; b_fbe = 0; b_freq = 0;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_outputs", {a_hv, a_hit, a_hw, a_busy, a_done}, 5'b0);
    chk("rst_b_outputs", {b_hv, b_hit, b_hw, b_busy, b_done}, 6'b0);
    rst = 1'b0;

    // Cold miss, then partial fill and byte-valid merge
    look(32'h100, 2'd2);      exp_a("cold_miss", 0, 0);
    fill(32'h100, 4'b0011);
    look(32'h100, 2'd1);      exp_a("half_lo_hit", 1, 0);
    look(32'h102, 2'd1);      exp_a("half_hi_miss", 0, 0);
    fill(32'h100, 4'b1100);
    look(32'h100, 2'd2);      exp_a("merged_word_hit", 1, 0);

    // Three tags in set 0 with two ways: first line is evicted
    fill(32'h1100, 4'hF);
    fill(32'h2100, 4'hF);
    look(32'h100, 2'd2);      exp_a("evicted_miss", 0, 0);
    look(32'h1100, 2'd2);     exp_a("way1_hit", 1, 1);
    look(32'h2100, 2'd2);     exp_a("victim_way0_hit", 1, 0);

    // Uncacheable, out-of-range and misaligned lookups
    fill(32'h4000_0000, 4'hF);
    look(32'h4000_0000, 2'd2); exp_a("mmio_miss", 0, 0);
    fill(32'h0001_0000, 4'hF);
    look(32'h0001_0000, 2'd2); exp_a("range_miss", 0, 0);
    look(32'h101, 2'd2);      exp_a("misaligned_miss", 0, 0);
    look(32'h2100, 2'd3);     exp_a("dword_on_32_miss", 0, 0);

    // Same-cycle fill and lookup sees pre-fill state
    cyc(1'b1, 32'h200, 2'd2, 1'b1, 32'h200, 4'hF, 1'b0); exp_a("rbw_miss", 0, 0);
    look(32'h200, 2'd2);      exp_a("rbw_next_hit", 1, 1);

    // Full flush with a fill attempted mid-flush
    fill(32'h304, 4'hF);
    fill(32'h308, 4'hF);
    fill(32'h30C, 4'hF);
    look(32'h308, 2'd2);      exp_a("pre_flush_hit", 1, 0);
    cyc(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      if (i == 5) fill(32'h404, 4'hF);
      else if (i == 9) cyc(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b1);
      else look(32'h304, 2'd2);
    end
    chk("flush_done_seen", a_done, 1'b1);
    look(32'h304, 2'd2);      exp_a("post_flush_miss_304", 0, 0);
    look(32'h1100, 2'd2);     exp_a("post_flush_miss_1100", 0, 0);
    look(32'h404, 2'd2);      exp_a("flush_fill_dropped", 0, 0);

    // Reset in the middle of a flush
    fill(32'h504, 4'hF);
    cyc(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 9; i++) idle();
    #2 rst = 1'b1;
    #1;
    chk("midflush_rst_busy", a_busy, 1'b0);
    chk("midflush_rst_done", a_done, 1'b0);
    mdl_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 70; i++) idle();
    look(32'h504, 2'd2);      exp_a("post_rst_miss", 0, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 3) != 0, rand_addr(), 2'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1, rand_addr(), 4'($urandom_range(0, 15)),
          $urandom_range(0, 299) == 0);
    end
    while (m_flushing) idle();

    // 64-bit, 4-way instance
    b_fv = 1'b1; b_fa = 64'h08; b_fbe = 8'hFF;
    idle();
    b_fv = 1'b0; b_lv = 1'b1; b_la = 64'h08; b_ls = 2'd3;
    idle();
    chk("b_dword_hit", {b_hv, b_hit, b_hw}, 4'b1100);
    b_la = 64'h0F; b_ls = 2'd0;
    idle();
    chk("b_byte_hit", {b_hv, b_hit, b_hw}, 4'b1100);
    b_la = 64'h0C; b_ls = 2'd3;
    idle();
    chk("b_misaligned_miss", {b_hv, b_hit, b_hw}, 4'b1000);
    b_lv = 1'b0; b_fv = 1'b1; b_fa = 64'h208; b_fbe = 8'hFF;
    idle();
    b_fv = 1'b0; b_lv = 1'b1; b_la = 64'h208; b_ls = 2'd3;
    idle();
    chk("b_second_way_hit", {b_hv, b_hit, b_hw}, 4'b1101);
    b_la = 64'h1_0000_0208;
    idle();
    chk("b_high_addr_miss", {b_hv, b_hit, b_hw}, 4'b1000);
    b_lv = 1'b0;
    idle();
    chk("b_idle", {b_hv, b_hit, b_busy, b_done}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
